// File: rtl/sata_prim_pkg.sv
// sata_prim_pkg
//   Shared SATA primitive definitions for the RX decoder and TX primitive generator.
//   Provides the 5-bit primitive code enum, the dword classification enum, the
//   K28.5/K28.3 lead-byte constants, the 32-bit primitive dwords and a lookup helper.
package sata_prim_pkg;

    typedef enum logic [4:0] {
        PRIM_NONE    = 5'd0,
        PRIM_ALIGN   = 5'd1,
        PRIM_SYNC    = 5'd2,
        PRIM_CONT    = 5'd3,
        PRIM_X_RDY   = 5'd4,
        PRIM_R_RDY   = 5'd5,
        PRIM_R_IP    = 5'd6,
        PRIM_R_OK    = 5'd7,
        PRIM_R_ERR   = 5'd8,
        PRIM_SOF     = 5'd9,
        PRIM_EOF     = 5'd10,
        PRIM_HOLD    = 5'd11,
        PRIM_HOLDA   = 5'd12,
        PRIM_WTRM    = 5'd13,
        PRIM_DMAT    = 5'd14,
        PRIM_PMREQ_P = 5'd15,
        PRIM_PMREQ_S = 5'd16,
        PRIM_PMACK   = 5'd17,
        PRIM_PMNAK   = 5'd18
    } prim_e;

    typedef enum logic [1:0] {
        CLS_DATA    = 2'd0,
        CLS_PRIM    = 2'd1,
        CLS_BADPRIM = 2'd2,
        CLS_BADK    = 2'd3
    } cls_e;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_3 = 8'h7C;

    localparam logic [31:0] DW_ALIGN   = 32'h7B4A4ABC;
    localparam logic [31:0] DW_SYNC    = 32'hB5B5957C;
    localparam logic [31:0] DW_CONT    = 32'h9999AA7C;
    localparam logic [31:0] DW_X_RDY   = 32'h5757B57C;
    localparam logic [31:0] DW_R_RDY   = 32'h4A4A957C;
    localparam logic [31:0] DW_R_IP    = 32'h5555B57C;
    localparam logic [31:0] DW_R_OK    = 32'h3535B57C;
    localparam logic [31:0] DW_R_ERR   = 32'h5656B57C;
    localparam logic [31:0] DW_SOF     = 32'h3737B57C;
    localparam logic [31:0] DW_EOF     = 32'hD5D5B57C;
    localparam logic [31:0] DW_HOLD    = 32'hD5D5AA7C;
    localparam logic [31:0] DW_HOLDA   = 32'h9595AA7C;
    localparam logic [31:0] DW_WTRM    = 32'h5858B57C;
    localparam logic [31:0] DW_DMAT    = 32'h3636B57C;
    localparam logic [31:0] DW_PMREQ_P = 32'h1717B57C;
    localparam logic [31:0] DW_PMREQ_S = 32'h7575957C;
    localparam logic [31:0] DW_PMACK   = 32'h9595957C;
    localparam logic [31:0] DW_PMNAK   = 32'hF5F5957C;

    // Full-dword match; PRIM_NONE when the dword is not a known primitive.
    function automatic prim_e prim_lookup(input logic [31:0] dw);
        case (dw)
            DW_ALIGN:   return PRIM_ALIGN;
            DW_SYNC:    return PRIM_SYNC;
            DW_CONT:    return PRIM_CONT;
            DW_X_RDY:   return PRIM_X_RDY;
            DW_R_RDY:   return PRIM_R_RDY;
            DW_R_IP:    return PRIM_R_IP;
            DW_R_OK:    return PRIM_R_OK;
            DW_R_ERR:   return PRIM_R_ERR;
            DW_SOF:     return PRIM_SOF;
            DW_EOF:     return PRIM_EOF;
            DW_HOLD:    return PRIM_HOLD;
            DW_HOLDA:   return PRIM_HOLDA;
            DW_WTRM:    return PRIM_WTRM;
            DW_DMAT:    return PRIM_DMAT;
            DW_PMREQ_P: return PRIM_PMREQ_P;
            DW_PMREQ_S: return PRIM_PMREQ_S;
            DW_PMACK:   return PRIM_PMACK;
            DW_PMNAK:   return PRIM_PMNAK;
            default:    return PRIM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sata_prim_lookup.sv
// sata_prim_lookup
//   Pure combinational classifier for one RX dword.
//   dword : 32-bit RX dword, byte0 in [7:0]
//   ctrl  : per-byte K flags, bit0 = byte0
//   cls   : DATA / PRIM / BADPRIM / BADK
//   code  : primitive code when cls == CLS_PRIM, else PRIM_NONE
module sata_prim_lookup
    import sata_prim_pkg::*;
(
    input  logic [31:0] dword,
    input  logic [3:0]  ctrl,
    output cls_e        cls,
    output prim_e       code
);

    prim_e match;

    assign match = prim_lookup(dword);

    // Every table entry carries K28.5 or K28.3 in byte0, so a full-dword match
    // implies the correct lead byte; any other K in byte0 lands on BADPRIM.
    always_comb begin
        cls  = CLS_BADK;
        code = PRIM_NONE;
        if (ctrl == 4'b0000) begin
            cls = CLS_DATA;
        end else if (ctrl == 4'b0001) begin
            if (match != PRIM_NONE) begin
                cls  = CLS_PRIM;
                code = match;
            end else begin
                cls = CLS_BADPRIM;
            end
        end
    end

endmodule

// File: rtl/sata_rx_prim_decoder.sv
// sata_rx_prim_decoder
//   Link-layer RX dword decoder: drops ALIGN, resolves CONT suppression,
//   forwards payload dwords and counts protocol errors. All outputs registered
//   with one clock of latency.
//   clk, rst_n         : link clock, async active-low reset
//   rx_sync            : adapter lock; dword ignored while low
//   rx_data, rx_ctrl   : RX dword and per-byte K flags
//   prim_valid/code    : decoded primitive (CONT resolved to the held primitive)
//   data_valid/out     : payload dword
//   err_pulse, err_cnt : one-cycle error strobe, saturating error count
module sata_rx_prim_decoder
    import sata_prim_pkg::*;
#(
    parameter bit          CONT_EN    = 1'b1,
    parameter bit          ALIGN_PASS = 1'b0,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_sync,
    input  logic [31:0]          rx_data,
    input  logic [3:0]           rx_ctrl,
    output logic                 prim_valid,
    output logic [4:0]           prim_code,
    output logic                 data_valid,
    output logic [31:0]          data_out,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {StNoSync, StRun, StHeld} state_e;

    localparam logic [ERR_CNT_W-1:0] CntOne = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    prim_e                hold_q, hold_d;
    logic                 pv_q, pv_d;
    prim_e                pc_q, pc_d;
    logic                 dv_q, dv_d;
    logic [31:0]          dout_q, dout_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    cls_e  cls;
    prim_e code;

    sata_prim_lookup u_lookup (
        .dword (rx_data),
        .ctrl  (rx_ctrl),
        .cls   (cls),
        .code  (code)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pv_d    = 1'b0;
        pc_d    = PRIM_NONE;
        dv_d    = 1'b0;
        dout_d  = dout_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (!rx_sync) begin
            state_d = StNoSync;
            hold_d  = PRIM_NONE;
        end else begin
            // Gaining lock decodes the same-cycle dword as in RUN; hold_q is
            // PRIM_NONE here, so a CONT is correctly treated as an orphan.
            if (state_q == StNoSync) begin
                state_d = StRun;
            end
            unique case (cls)
                CLS_DATA: begin
                    if (state_q == StHeld) begin
                        // Junk under CONT: keep repeating the held primitive.
                        pv_d = 1'b1;
                        pc_d = hold_q;
                    end else begin
                        dv_d   = 1'b1;
                        dout_d = rx_data;
                    end
                end
                CLS_PRIM: begin
                    if (code == PRIM_ALIGN) begin
                        if (ALIGN_PASS) begin
                            pv_d = 1'b1;
                            pc_d = PRIM_ALIGN;
                        end
                    end else if (CONT_EN && code == PRIM_CONT) begin
                        if (state_q == StHeld) begin
                            pv_d = 1'b1;
                            pc_d = hold_q;
                        end else if (hold_q == PRIM_NONE) begin
                            err_d = 1'b1;
                        end else begin
                            pv_d    = 1'b1;
                            pc_d    = hold_q;
                            state_d = StHeld;
                        end
                    end else begin
                        pv_d    = 1'b1;
                        pc_d    = code;
                        hold_d  = code;
                        state_d = StRun;
                    end
                end
                CLS_BADPRIM, CLS_BADK: err_d = 1'b1;
                default: ;
            endcase
            if (err_d && cnt_q != '1) begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StNoSync;
            hold_q  <= PRIM_NONE;
            pv_q    <= 1'b0;
            pc_q    <= PRIM_NONE;
            dv_q    <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pv_q    <= pv_d;
            pc_q    <= pc_d;
            dv_q    <= dv_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign prim_valid = pv_q;
    assign prim_code  = pc_q;
    assign data_valid = dv_q;
    assign data_out   = dout_q;
    assign err_pulse  = err_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_sata_rx_prim_decoder.sv
// tb_sata_rx_prim_decoder
//   Directed-vector bench for sata_rx_prim_decoder (default parameters).
//   Inputs change on the falling edge; outputs are sampled one falling edge later.
module tb_sata_rx_prim_decoder;
    import sata_prim_pkg::*;

    localparam logic [3:0] KC = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_sync = 1'b0;
    logic [31:0] rx_data = '0;
    logic [3:0]  rx_ctrl = '0;
    logic        prim_valid;
    logic [4:0]  prim_code;
    logic        data_valid;
    logic [31:0] data_out;
    logic        err_pulse;
    logic [15:0] err_cnt;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_err = '0;

    always #5 clk = ~clk;

    sata_rx_prim_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_sync    (rx_sync),
        .rx_data    (rx_data),
        .rx_ctrl    (rx_ctrl),
        .prim_valid (prim_valid),
        .prim_code  (prim_code),
        .data_valid (data_valid),
        .data_out   (data_out),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
    );

    // Present one dword, then return on the falling edge where its result is visible.
    task automatic step(input logic [31:0] d, input logic [3:0] c, input logic s);
        rx_data = d;
        rx_ctrl = c;
        rx_sync = s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({prim_valid, prim_code, data_valid, data_out, err_pulse, err_cnt} !== '0)
            $display("FAIL reset_idle: pv=%b pc=%0d dv=%b do=%h ep=%b ec=%0d, want all 0",
                     prim_valid, prim_code, data_valid, data_out, err_pulse, err_cnt);
        else n_pass++;
        rst_n = 1'b1;
        step(DW_SYNC, KC, 1'b1);
        step(DW_X_RDY, KC, 1'b1);
        n_checks++;
        if (!(prim_valid === 1'b1 && prim_code === PRIM_X_RDY))
            $display("FAIL stream_before_reset: pv=%b pc=%0d, want 1/%0d",
                     prim_valid, prim_code, PRIM_X_RDY);
        else n_pass++;
        // Assert reset between clock edges: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({prim_valid, prim_code, data_valid, data_out, err_pulse, err_cnt} !== '0)
            $display("FAIL async_reset: pv=%b pc=%0d dv=%b ep=%b ec=%0d, want all 0",
                     prim_valid, prim_code, data_valid, err_pulse, err_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        rx_sync = 1'b1;
        rx_data = DW_SYNC;
        rx_ctrl = KC;
        #1;
        n_checks++;
        if ({prim_valid, prim_code, data_valid, err_pulse} !== '0)
            $display("FAIL pre_first_decode: pv=%b pc=%0d dv=%b ep=%b, want 0",
                     prim_valid, prim_code, data_valid, err_pulse);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({prim_valid, prim_code, data_valid, err_pulse} !== {1'b1, PRIM_SYNC, 1'b0, 1'b0})
            $display("FAIL first_sync: pv=%b pc=%0d dv=%b ep=%b, want 1/%0d/0/0",
                     prim_valid, prim_code, data_valid, err_pulse, PRIM_SYNC);
        else n_pass++;
    endtask

    task automatic test_orphan_cont();
        step(32'h0, 4'b0000, 1'b0);
        step(DW_CONT, KC, 1'b1);
        exp_err = exp_err + 16'd1;
        n_checks++;
        if ({prim_valid, data_valid, err_pulse, err_cnt} !== {1'b0, 1'b0, 1'b1, exp_err})
            $display("FAIL orphan_cont: pv=%b dv=%b ep=%b ec=%0d, want 0/0/1/%0d",
                     prim_valid, data_valid, err_pulse, err_cnt, exp_err);
        else n_pass++;
        step(DW_SYNC, KC, 1'b1);
        n_checks++;
        if ({prim_valid, prim_code, err_pulse, err_cnt} !== {1'b1, PRIM_SYNC, 1'b0, exp_err})
            $display("FAIL orphan_pulse_once: pv=%b pc=%0d ep=%b ec=%0d, want 1/%0d/0/%0d",
                     prim_valid, prim_code, err_pulse, err_cnt, PRIM_SYNC, exp_err);
        else n_pass++;
    endtask

    task automatic test_cont_hold();
        logic [31:0] din [7];
        logic [3:0]  cin [7];
        logic [4:0]  exp [7];
        din = '{DW_X_RDY, DW_X_RDY, DW_CONT, $urandom, $urandom, $urandom, DW_SOF};
        cin = '{KC, KC, KC, 4'b0000, 4'b0000, 4'b0000, KC};
        exp = '{PRIM_X_RDY, PRIM_X_RDY, PRIM_X_RDY, PRIM_X_RDY, PRIM_X_RDY, PRIM_X_RDY, PRIM_SOF};
        for (int i = 0; i < 7; i++) begin
            step(din[i], cin[i], 1'b1);
            n_checks++;
            if ({prim_valid, prim_code, data_valid, err_pulse} !== {1'b1, exp[i], 1'b0, 1'b0})
                $display("FAIL cont_hold[%0d]: pv=%b pc=%0d dv=%b ep=%b, want 1/%0d/0/0",
                         i, prim_valid, prim_code, data_valid, err_pulse, exp[i]);
            else n_pass++;
        end
        n_checks++;
        if (err_cnt !== exp_err)
            $display("FAIL cont_hold_errcnt: ec=%0d, want %0d", err_cnt, exp_err);
        else n_pass++;
    endtask

    task automatic test_align_hold();
        logic [31:0] din [6];
        logic [3:0]  cin [6];
        logic        epv [6];
        logic [4:0]  exp [6];
        din = '{DW_HOLD, DW_CONT, DW_ALIGN, DW_ALIGN, $urandom, DW_R_IP};
        cin = '{KC, KC, KC, KC, 4'b0000, KC};
        epv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{PRIM_HOLD, PRIM_HOLD, PRIM_NONE, PRIM_NONE, PRIM_HOLD, PRIM_R_IP};
        for (int i = 0; i < 6; i++) begin
            step(din[i], cin[i], 1'b1);
            n_checks++;
            if ({prim_valid, prim_code, data_valid, err_pulse} !== {epv[i], exp[i], 1'b0, 1'b0})
                $display("FAIL align_hold[%0d]: pv=%b pc=%0d dv=%b ep=%b, want %b/%0d/0/0",
                         i, prim_valid, prim_code, data_valid, err_pulse, epv[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_data();
        logic [31:0] din [4];
        logic [3:0]  cin [4];
        logic        epv [4];
        logic [4:0]  exp [4];
        din = '{DW_SOF, 32'h01234567, 32'h89ABCDEF, DW_EOF};
        cin = '{KC, 4'b0000, 4'b0000, KC};
        epv = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp = '{PRIM_SOF, PRIM_NONE, PRIM_NONE, PRIM_EOF};
        for (int i = 0; i < 4; i++) begin
            step(din[i], cin[i], 1'b1);
            n_checks++;
            if ({prim_valid, prim_code, data_valid, err_pulse} !== {epv[i], exp[i], !epv[i], 1'b0}
                || (!epv[i] && data_out !== din[i]))
                $display("FAIL data[%0d]: pv=%b pc=%0d dv=%b do=%h ep=%b, want %b/%0d/%b/%h/0",
                         i, prim_valid, prim_code, data_valid, data_out, err_pulse,
                         epv[i], exp[i], !epv[i], din[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        // Repeated CONT stays HELD without error; a new primitive re-opens payload.
        logic [31:0] din [6];
        logic [3:0]  cin [6];
        logic        epv [6];
        logic [4:0]  exp [6];
        din = '{DW_X_RDY, DW_CONT, DW_CONT, 32'hCAFEF00D, DW_R_OK, 32'h5A5AA5A5};
        cin = '{KC, KC, KC, 4'b0000, KC, 4'b0000};
        epv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp = '{PRIM_X_RDY, PRIM_X_RDY, PRIM_X_RDY, PRIM_X_RDY, PRIM_R_OK, PRIM_NONE};
        for (int i = 0; i < 6; i++) begin
            step(din[i], cin[i], 1'b1);
            n_checks++;
            if ({prim_valid, prim_code, data_valid, err_pulse} !== {epv[i], exp[i], !epv[i], 1'b0}
                || (!epv[i] && data_out !== din[i]))
                $display("FAIL b2b[%0d]: pv=%b pc=%0d dv=%b do=%h ep=%b, want %b/%0d/%b/%h/0",
                         i, prim_valid, prim_code, data_valid, data_out, err_pulse,
                         epv[i], exp[i], !epv[i], din[i]);
            else n_pass++;
        end
    endtask

    task automatic test_err_sat();
        step(32'h12345678, 4'b0010, 1'b1);
        exp_err = exp_err + 16'd1;
        n_checks++;
        if ({prim_valid, data_valid, err_pulse, err_cnt} !== {1'b0, 1'b0, 1'b1, exp_err})
            $display("FAIL badk: pv=%b dv=%b ep=%b ec=%0d, want 0/0/1/%0d",
                     prim_valid, data_valid, err_pulse, err_cnt, exp_err);
        else n_pass++;
        for (int i = 0; i < 65538; i++) begin
            step(i[0] ? 32'h0000007C : 32'h000000BC, KC, 1'b1);
            if (i == 99) begin
                n_checks++;
                if (err_cnt !== exp_err + 16'd100)
                    $display("FAIL badprim_count: ec=%0d, want %0d", err_cnt, exp_err + 16'd100);
                else n_pass++;
            end
        end
        n_checks++;
        if ({prim_valid, err_pulse, err_cnt} !== {1'b0, 1'b1, 16'hFFFF})
            $display("FAIL err_saturate: pv=%b ep=%b ec=%h, want 0/1/ffff",
                     prim_valid, err_pulse, err_cnt);
        else n_pass++;
        step(DW_HOLD, KC, 1'b1);
        step(DW_CONT, KC, 1'b1);
        n_checks++;
        if ({prim_valid, prim_code, err_pulse, err_cnt} !== {1'b1, PRIM_HOLD, 1'b0, 16'hFFFF})
            $display("FAIL held_before_drop: pv=%b pc=%0d ep=%b ec=%h, want 1/%0d/0/ffff",
                     prim_valid, prim_code, err_pulse, err_cnt, PRIM_HOLD);
        else n_pass++;
        step(DW_HOLD, KC, 1'b0);
        n_checks++;
        if ({prim_valid, prim_code, data_valid, err_pulse} !== '0)
            $display("FAIL sync_drop_idle: pv=%b pc=%0d dv=%b ep=%b, want all 0",
                     prim_valid, prim_code, data_valid, err_pulse);
        else n_pass++;
        // Held primitive must have been cleared by the sync drop.
        step(DW_CONT, KC, 1'b1);
        n_checks++;
        if ({prim_valid, err_pulse, err_cnt} !== {1'b0, 1'b1, 16'hFFFF})
            $display("FAIL hold_cleared: pv=%b ep=%b ec=%h, want 0/1/ffff",
                     prim_valid, err_pulse, err_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_orphan_cont();
        test_cont_hold();
        test_align_hold();
        test_data();
        test_back_to_back();
        test_err_sat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
